if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/if_stage_if.sv | 10 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/if_stage.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants, opcode values and the fetch FSM encoding.
package if_stage_pkg;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEF = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};
  localparam logic [63:0] RESET_PC_DEF  = 64'h0;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  function automatic logic [63:0] pc_plus4(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_stage_if;
  logic        req;
  logic [63:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word or flushes to a bubble.
// A bubble keeps the previous pc and presents NOP_INSTR with valid low.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [63:0] i_pc,
  input  logic [31:0] i_instr,
  output logic [63:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [63:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;

  // Reset wins, then flush-to-bubble, then a real load.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, one-entry fetch buffer and fetch FSM.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_FETCH   | request outstanding at r_pc
// ST_HOLD    | fetched word parked in the buffer, memory idle
// ST_DISCARD | stale request still outstanding at r_disc_addr; drop its data
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_pc_load,
  input  logic              i_if_id_load,
  input  logic              i_branch_taken,
  input  logic [63:0]       i_branch_target,
  if_stage_if.master        imem,
  output logic [63:0]       o_if_id_pc,
  output logic [31:0]       o_if_id_instr,
  output logic              o_if_id_valid
);

  fetch_state_t r_state;
  logic [63:0]  r_pc;
  logic [63:0]  r_buf_pc;
  logic [31:0]  r_buf_instr;
  logic [63:0]  r_disc_addr;

  fetch_state_t w_state_nxt;
  logic [63:0]  w_pc_nxt;
  logic         w_advance;
  logic         w_buf_we;
  logic         w_disc_we;
  logic         w_id_load;
  logic         w_id_flush;
  logic [63:0]  w_id_pc;
  logic [31:0]  w_id_instr;

  // The stale request must keep its own address even after PC is redirected.
  assign imem.req  = reset && (r_state != ST_HOLD);
  assign imem.addr = (r_state == ST_DISCARD) ? r_disc_addr : r_pc;

  assign w_id_pc    = (r_state == ST_HOLD) ? r_buf_pc    : r_pc;
  assign w_id_instr = (r_state == ST_HOLD) ? r_buf_instr : imem.rdata;

  // Next state, next PC and IF/ID control; a redirect overrides everything.
  // When IF/ID is allowed to load but has no new word it takes a bubble, so
  // the decode stage never sees the same instruction twice.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_advance   = i_pc_load && i_if_id_load;
    w_buf_we    = 1'b0;
    w_disc_we   = 1'b0;
    w_id_load   = 1'b0;
    w_id_flush  = 1'b0;

    if (i_branch_taken) begin
      w_pc_nxt   = i_branch_target;
      w_id_flush = 1'b1;
      unique case (r_state)
        ST_FETCH: begin
          if (!imem.ack) begin
            w_state_nxt = ST_DISCARD;
            w_disc_we   = 1'b1;
          end
        end
        ST_HOLD:  w_state_nxt = ST_FETCH;
        default:  w_state_nxt = ST_DISCARD;
      endcase
    end else begin
      unique case (r_state)
        ST_FETCH: begin
          if (imem.ack && w_advance) begin
            w_id_load = 1'b1;
            w_pc_nxt  = pc_plus4(r_pc);
          end else if (imem.ack) begin
            w_buf_we    = 1'b1;
            w_state_nxt = ST_HOLD;
            w_id_flush  = i_if_id_load;
          end else begin
            w_id_flush  = i_if_id_load;
          end
        end
        ST_HOLD: begin
          if (w_advance) begin
            w_id_load   = 1'b1;
            w_pc_nxt    = pc_plus4(r_pc);
            w_state_nxt = ST_FETCH;
          end else begin
            w_id_flush  = i_if_id_load;
          end
        end
        default: begin
          if (imem.ack) begin
            w_state_nxt = ST_FETCH;
          end
          w_id_flush = i_if_id_load;
        end
      endcase
    end
  end

  // FSM, PC, fetch buffer and stale-request address registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_buf_pc    <= '0;
      r_buf_instr <= NOP_INSTR;
      r_disc_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_buf_we) begin
        r_buf_pc    <= r_pc;
        r_buf_instr <= imem.rdata;
      end
      if (w_disc_we) begin
        r_disc_addr <= r_pc;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_id_load),
    .i_flush (w_id_flush),
    .i_pc    (w_id_pc),
    .i_instr (w_id_instr),
    .o_pc    (o_if_id_pc),
    .o_instr (o_if_id_instr),
    .o_valid (o_if_id_valid)
  );

endmodule
